// File: rtl/ball_motion_engine.sv
// Single-ball motion engine for the BrickBreaker raster pipeline: probe-pixel contact
// detection, sticky brick mask, and a serve/play/lost/over life cycle, all paced by end-of-frame.
module ball_motion_engine #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int BALL_SZ  = 7,
  parameter int N_BRICKS = 140,
  parameter int SPEED_W  = 3,
  parameter int START_X  = 323,
  parameter int START_Y  = 440,
  parameter int LIVES    = 3
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [9:0]          xpos,
  input  logic [9:0]          ypos,
  input  logic                iPaddle,
  input  logic [N_BRICKS-1:0] iBrick,
  input  logic                iRun,
  input  logic                iServe,
  input  logic [SPEED_W-1:0]  iSpeed,
  input  logic                iNewGame,
  output logic                oBall,
  output logic [9:0]          oBallX,
  output logic [9:0]          oBallY,
  output logic [N_BRICKS-1:0] oHitMask,
  output logic                oBrickHit,
  output logic                oBottomHit,
  output logic [3:0]          oLives,
  output logic                oGameOver
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_LOST, S_OVER} state_t;

  localparam int          MID  = BALL_SZ / 2;
  localparam logic [10:0] XMAX = 11'(H_RES - BALL_SZ);
  localparam logic [10:0] YMAX = 11'(V_RES - BALL_SZ);
  localparam logic [9:0]  SX   = 10'(START_X);
  localparam logic [9:0]  SY   = 10'(START_Y);

  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic                dirx_q, dirx_d, diry_q, diry_d;  // 1 = increasing coordinate
  logic                bncx_q, bncx_d, bncy_q, bncy_d, lost_q, lost_d;
  logic [N_BRICKS-1:0] mask_q, mask_d;
  logic                bhit_q, bhit_d;
  logic [3:0]          lives_q, lives_d;

  logic [10:0] px, py, bx, by, x11, y11;
  logic        eof, hl, hr, ht, hb, any_probe, obj;
  logic [N_BRICKS-1:0] live;

  // Clamped 11-bit step so neither underflow nor overflow can wrap the position.
  function automatic logic [9:0] step(input logic [9:0] p, input logic dir,
                                      input logic [SPEED_W-1:0] s, input logic [10:0] mx);
    logic [10:0] p11, s11, r;
    p11 = {1'b0, p};
    s11 = 11'(s);
    if (dir) r = (p11 + s11 > mx) ? mx : p11 + s11;
    else     r = (s11 > p11) ? 11'd0 : p11 - s11;
    return r[9:0];
  endfunction

  assign px  = {1'b0, xpos};
  assign py  = {1'b0, ypos};
  assign x11 = {1'b0, x_q};
  assign y11 = {1'b0, y_q};
  assign bx  = x11 + 11'(BALL_SZ - 1);
  assign by  = y11 + 11'(BALL_SZ - 1);
  assign eof = (xpos == 10'd0) && (ypos == 10'(V_RES - 1));

  assign hl = (px == x11) && (py == y11 + 11'(MID));
  assign hr = (px == bx)  && (py == y11 + 11'(MID));
  assign ht = (px == x11 + 11'(MID)) && (py == y11);
  assign hb = (px == x11 + 11'(MID)) && (py == by);
  assign any_probe = hl | hr | ht | hb;
  assign live = iBrick & ~mask_q;
  assign obj  = iPaddle | (|live);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dirx_d  = dirx_q;
    diry_d  = diry_q;
    bncx_d  = bncx_q;
    bncy_d  = bncy_q;
    lost_d  = lost_q;
    mask_d  = mask_q;
    bhit_d  = 1'b0;
    lives_d = lives_q;
    if (iNewGame) begin
      state_d = S_SERVE;
      x_d     = SX;
      y_d     = SY;
      dirx_d  = 1'b1;
      diry_d  = 1'b0;
      bncx_d  = 1'b0;
      bncy_d  = 1'b0;
      lost_d  = 1'b0;
      mask_d  = '0;
      lives_d = 4'(LIVES);
    end else begin
      case (state_q)
        S_SERVE: begin
          x_d = SX;
          y_d = SY;
          {bncx_d, bncy_d, lost_d} = 3'b000;
          if (eof && iRun && iServe) begin
            state_d = S_PLAY;
            dirx_d  = 1'b1;
            diry_d  = 1'b0;
            x_d     = step(SX, 1'b1, iSpeed, XMAX);
            y_d     = step(SY, 1'b0, iSpeed, YMAX);
          end
        end
        S_PLAY: if (iRun) begin
          if (eof) begin
            {bncx_d, bncy_d, lost_d} = 3'b000;
            if (lost_q) state_d = S_LOST;
            else begin
              dirx_d = dirx_q ^ bncx_q;
              diry_d = diry_q ^ bncy_q;
              x_d    = step(x_q, dirx_q ^ bncx_q, iSpeed, XMAX);
              y_d    = step(y_q, diry_q ^ bncy_q, iSpeed, YMAX);
            end
          end else begin
            if (((ht | hb) && obj) || (ht && ypos == 10'd0)) bncy_d = 1'b1;
            if (((hl | hr) && obj) || (hl && xpos == 10'd0) ||
                (hr && xpos == 10'(H_RES - 1))) bncx_d = 1'b1;
            if (hb && ypos == 10'(V_RES - 1)) lost_d = 1'b1;
            if (any_probe) begin
              mask_d = mask_q | live;
              bhit_d = |live;
            end
          end
        end
        S_LOST: begin
          lives_d = lives_q - 4'd1;
          x_d     = SX;
          y_d     = SY;
          {bncx_d, bncy_d, lost_d} = 3'b000;
          state_d = (lives_q <= 4'd1) ? S_OVER : S_SERVE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_SERVE;
      x_q     <= SX;
      y_q     <= SY;
      dirx_q  <= 1'b1;
      diry_q  <= 1'b0;
      bncx_q  <= 1'b0;
      bncy_q  <= 1'b0;
      lost_q  <= 1'b0;
      mask_q  <= '0;
      bhit_q  <= 1'b0;
      lives_q <= 4'(LIVES);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
      bncx_q  <= bncx_d;
      bncy_q  <= bncy_d;
      lost_q  <= lost_d;
      mask_q  <= mask_d;
      bhit_q  <= bhit_d;
      lives_q <= lives_d;
    end
  end

  assign oBall      = (px >= x11) && (px <= bx) && (py >= y11) && (py <= by);
  assign oBallX     = x_q;
  assign oBallY     = y_q;
  assign oHitMask   = mask_q;
  assign oBrickHit  = bhit_q;
  assign oBottomHit = (state_q == S_LOST);
  assign oLives     = lives_q;
  assign oGameOver  = (state_q == S_OVER);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: pixels are injected one per clock, so a
// "frame" is just a few contact pixels followed by the EOF pixel (0,479).
module tb_ball_motion_engine;
  localparam int NB = 140;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [9:0]    xpos = 10'd100, ypos = 10'd100;
  logic          iPaddle = 1'b0;
  logic [NB-1:0] iBrick = '0;
  logic          iRun = 1'b0, iServe = 1'b0, iNewGame = 1'b0;
  logic [2:0]    iSpeed = 3'd0;
  logic          oBall, oBrickHit, oBottomHit, oGameOver;
  logic [9:0]    oBallX, oBallY;
  logic [NB-1:0] oHitMask;
  logic [3:0]    oLives;

  int total = 0;
  int bad   = 0;

  ball_motion_engine dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .xpos(xpos), .ypos(ypos), .iPaddle(iPaddle),
    .iBrick(iBrick), .iRun(iRun), .iServe(iServe), .iSpeed(iSpeed), .iNewGame(iNewGame),
    .oBall(oBall), .oBallX(oBallX), .oBallY(oBallY), .oHitMask(oHitMask),
    .oBrickHit(oBrickHit), .oBottomHit(oBottomHit), .oLives(oLives), .oGameOver(oGameOver)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       exp;
  } bvec_t;

  bvec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic pad, input logic [NB-1:0] brk);
    @(negedge iCLK);
    xpos    = 10'(x);
    ypos    = 10'(y);
    iPaddle = pad;
    iBrick  = brk;
    @(posedge iCLK);
    #1;
  endtask

  task automatic eof();
    pix(0, 479, 1'b0, '0);
  endtask

  task automatic new_game();
    @(negedge iCLK);
    iNewGame = 1'b1;
    xpos = 10'd100; ypos = 10'd100; iPaddle = 1'b0; iBrick = '0;
    @(posedge iCLK);
    #1;
    @(negedge iCLK);
    iNewGame = 1'b0;
  endtask

  // Serve at speed 7, bounce down off the paddle, sink to the floor and lose the ball.
  task automatic lose_ball(input int lives_after);
    eof();
    chk("lose_serve_x", oBallX, 330);
    pix(333, 439, 1'b1, '0);
    eof();
    chk("lose_bounce_y", oBallY, 440);
    for (int i = 0; i < 5; i++) eof();
    chk("lose_floor_y", oBallY, 473);
    chk("lose_floor_x", oBallX, 372);
    pix(375, 479, 1'b0, '0);
    eof();
    chk("lost_pulse", oBottomHit, 1);
    pix(100, 100, 1'b0, '0);
    chk("lives_after", oLives, lives_after);
    chk("lost_pulse_end", oBottomHit, 0);
    chk("lost_reload_x", oBallX, 323);
  endtask

  initial begin
    logic [NB-1:0] b17, b5;
    b17 = '0; b17[17] = 1'b1;
    b5  = '0; b5[5]   = 1'b1;

    tbl[0] = '{10'd323, 10'd440, 1'b1};
    tbl[1] = '{10'd329, 10'd446, 1'b1};
    tbl[2] = '{10'd326, 10'd443, 1'b1};
    tbl[3] = '{10'd322, 10'd440, 1'b0};
    tbl[4] = '{10'd330, 10'd443, 1'b0};
    tbl[5] = '{10'd326, 10'd439, 1'b0};
    tbl[6] = '{10'd326, 10'd447, 1'b0};
    tbl[7] = '{10'd329, 10'd440, 1'b1};

    // Reset state
    #12;
    chk("rst_x", oBallX, 323);
    chk("rst_y", oBallY, 440);
    chk("rst_mask", int'(|oHitMask), 0);
    chk("rst_lives", oLives, 3);
    chk("rst_over", oGameOver, 0);
    chk("rst_hit", oBrickHit, 0);
    chk("rst_bottom", oBottomHit, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Ball pixel window at the serve position
    foreach (tbl[i]) begin
      @(negedge iCLK);
      xpos = tbl[i].x;
      ypos = tbl[i].y;
      #1;
      chk($sformatf("oball_%0d", i), oBall, tbl[i].exp);
    end

    // Serve
    iRun = 1'b1; iServe = 1'b1; iSpeed = 3'd2;
    eof();
    chk("serve_x", oBallX, 325);
    chk("serve_y", oBallY, 438);

    // Paddle under B probe twice: down, then back up
    pix(328, 444, 1'b1, '0);
    eof();
    chk("pad1_y", oBallY, 440);
    chk("pad1_x", oBallX, 327);
    pix(330, 446, 1'b1, '0);
    eof();
    chk("pad2_y", oBallY, 438);

    // Brick 17 at T probe: hit, then destroyed brick is transparent
    pix(332, 438, 1'b0, b17);
    chk("b17_pulse", oBrickHit, 1);
    chk("b17_mask", oHitMask[17], 1);
    pix(100, 100, 1'b0, '0);
    chk("b17_pulse_end", oBrickHit, 0);
    eof();
    chk("b17_bounce_y", oBallY, 440);
    chk("b17_bounce_x", oBallX, 331);
    pix(334, 440, 1'b0, b17);
    chk("b17_nopulse", oBrickHit, 0);
    eof();
    chk("b17_nobounce_y", oBallY, 442);

    // Right-wall clamp and wall bounce
    new_game();
    chk("ng_mask", int'(|oHitMask), 0);
    chk("ng_x", oBallX, 323);
    iSpeed = 3'd3;
    for (int i = 0; i < 103; i++) eof();
    chk("run_x", oBallX, 632);
    chk("run_y", oBallY, 131);
    iSpeed = 3'd7;
    eof();
    chk("clamp_x", oBallX, 633);
    chk("clamp_y", oBallY, 124);
    pix(639, 127, 1'b0, '0);
    eof();
    chk("wall_x", oBallX, 626);
    chk("wall_y", oBallY, 117);

    // Pause with contacts present
    iRun = 1'b0;
    for (int f = 0; f < 5; f++) begin
      pix(629, 123, 1'b1, '0);
      pix(629, 117, 1'b0, b5);
      chk("pause_pulse", oBrickHit, 0);
      eof();
    end
    chk("pause_x", oBallX, 626);
    chk("pause_y", oBallY, 117);
    chk("pause_mask", int'(|oHitMask), 0);
    iRun = 1'b1;
    eof();
    chk("resume_x", oBallX, 619);
    chk("resume_y", oBallY, 110);

    // Lose all lives
    new_game();
    lose_ball(2);
    lose_ball(1);
    lose_ball(0);
    chk("over", oGameOver, 1);
    eof();
    chk("over_frozen_x", oBallX, 323);
    chk("over_hold", oGameOver, 1);
    new_game();
    chk("ng2_lives", oLives, 3);
    chk("ng2_over", oGameOver, 0);
    chk("ng2_mask", int'(|oHitMask), 0);
    eof();
    chk("ng2_serve_x", oBallX, 330);

    // Async reset mid-cycle
    @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    chk("areset_x", oBallX, 323);
    chk("areset_y", oBallY, 440);
    #4 iRST_N = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
